instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Owns the architectural PC and fetches one instruction at a time from instruction memory over a
//  valid/ready request + valid response interface. Holds the fetched word stable for decode/execute.
//  Sits directly upstream of decode and consumes new_pc from pc_mux. pc_plus4 feeds pc_mux
//  default_pc_write and the JAL/JALR link value into rd_mux.
//  Single outstanding request; no prediction, no prefetch.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC loaded on reset; must be 4-byte aligned
// PORTS
//  clk             in   1   single clock; all state updates on posedge
//  rst_n           in   1   asynchronous, active-low reset
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request this cycle
//  imem_addr       out  32  fetch address; always equals pc
//  imem_resp_valid in   1   response data valid
//  imem_resp_data  in   32  fetched instruction word
//  instr_valid     out  1   instr holds a fetched, unretired instruction
//  instr           out  32  instruction to decode
//  pc              out  32  address of instr
//  pc_plus4        out  32  pc + 4, modulo 2^32
//  retire          in   1   execute has finished instr; sample new_pc
//  new_pc          in   32  next PC from pc_mux
//  fetch_fault     out  1   sticky: misaligned new_pc was retired
//  retired_count   out  32  count of accepted retires, wraps
// BEHAVIOUR
//  Reset (rst_n low, async):
//  - state=REQUEST, pc=RESET_VECTOR, instr=32'h0000_0013 (NOP), instr_valid=0.
//  - fetch_fault=0, retired_count=0.
//  - imem_req_valid is 1 in the first cycle after release.
//  - instruction memory shares rst_n; no response from before reset can arrive after it.
//  FSM: REQUEST, WAIT, ISSUE, FAULT; 2-bit encoding. Outputs are decoded from registered state.
//  - REQUEST: imem_req_valid=1, imem_addr=pc. When imem_req_ready=1 -> WAIT.
//    imem_resp_valid is ignored in this state.
//  - WAIT: imem_req_valid=0. When imem_resp_valid=1: instr<=imem_resp_data, instr_valid<=1 -> ISSUE.
//  - ISSUE: instr, pc and instr_valid stay stable until retire=1. On retire:
//    - retired_count += 1.
//    - new_pc[1:0]==0: pc<=new_pc, instr_valid<=0 -> REQUEST.
//    - otherwise: fetch_fault<=1, instr_valid<=0, pc unchanged -> FAULT.
//  - FAULT: terminal until reset. No requests; retire ignored.
//  - retire outside ISSUE is ignored: no count, no PC change.
//  Latency:
//  - request accept -> WAIT next cycle. resp_valid -> instr_valid next cycle.
//  - retire -> imem_req_valid next cycle.
//  - Minimum 3 cycles per instruction with zero-wait memory.
//  - Memory responds no earlier than the cycle after acceptance.
//  Width and wrap:
//  - pc_plus4 = pc + 32'd4 wraps (32'hFFFF_FFFC -> 0).
//  - retired_count wraps 32'hFFFF_FFFF -> 0.
//  Simultaneous events:
//  - retire with new_pc == pc re-fetches the same address (self-loop is legal).
//  - If imem_req_ready is held high for many cycles, only one acceptance is registered; state leaves REQUEST.
//  Reset mid-operation (any state) forces the reset values immediately. No partial PC update survives.
// STRUCTURE
//  - Shared package (define.vh): fetch FSM state encodings, NOP encoding 32'h0000_0013,
//    default RESET_VECTOR macro.
//  - Single module: FSM, PC register, instr latch and counter are tightly coupled.
//    No sub-module is warranted.
// TESTING
//  1. Reset with RESET_VECTOR=32'h100, zero-wait memory:
//     -> first req addr 32'h100; instr_valid 2 cycles after acceptance; pc_plus4=32'h104.
//  2. Hold imem_req_ready=0 for 5 cycles, then 1:
//     -> req_valid and addr stable throughout; exactly one acceptance.
//  3. Response delayed 4 cycles, resp_data=32'h00500093:
//     -> instr matches; instr_valid stays 0 until the cycle after resp_valid.
//  4. Retire with new_pc=32'h200, then again with new_pc=32'h200:
//     -> two fetches at 32'h200; retired_count=2.
//  5. Retire with new_pc=32'h202:
//     -> fetch_fault=1 sticky; no further imem_req_valid; later retires leave retired_count unchanged.
//  6. Assert rst_n low while in WAIT, and pulse retire in REQUEST:
//     -> immediate reset values; the stray retire is ignored.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch definitions: FSM state encodings, NOP word, default reset vector.
// No logic; types and constants only.
// Imported by the fetch unit and anything that needs to decode its state.
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        ST_REQUEST = 2'b00,
        ST_WAIT    = 2'b01,
        ST_ISSUE   = 2'b10,
        ST_FAULT   = 2'b11
    } fetch_state_t;

    // addi x0, x0, 0 -- what decode sees before the first real fetch lands
    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    // Instruction addresses must be word aligned
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Purpose: owns the PC, fetches one instruction at a time and holds it stable for decode/execute.
// Latency: request accept -> WAIT next cycle; resp_valid -> instr_valid next cycle; retire -> req next cycle.
// Backpressure: request held (addr stable) until imem_req_ready; instr held until retire; single outstanding.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        retire,
    input  logic [31:0] new_pc,
    output logic        fetch_fault,
    output logic [31:0] retired_count
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_fetch_fault;
    logic [31:0] r_retired_count;

    logic        w_req_accept;
    logic        w_resp_take;
    logic        w_retire_take;
    logic        w_new_pc_ok;

    // Events only count in the state that owns them; everything else is ignored
    assign w_req_accept  = (r_state == ST_REQUEST) && imem_req_ready;
    assign w_resp_take   = (r_state == ST_WAIT)    && imem_resp_valid;
    assign w_retire_take = (r_state == ST_ISSUE)   && retire;
    assign w_new_pc_ok   = is_word_aligned(new_pc);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_REQUEST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; FAULT only leaves through reset
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_REQUEST: if (w_req_accept)  w_state_nxt = ST_WAIT;
            ST_WAIT:    if (w_resp_take)   w_state_nxt = ST_ISSUE;
            ST_ISSUE:   if (w_retire_take) w_state_nxt = w_new_pc_ok ? ST_REQUEST : ST_FAULT;
            ST_FAULT:   w_state_nxt = ST_FAULT;
            default:    w_state_nxt = ST_REQUEST;
        endcase
    end

    // PC, instruction latch, fault flag and retire counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc            <= RESET_VECTOR;
            r_instr         <= NOP_INSTR;
            r_instr_valid   <= 1'b0;
            r_fetch_fault   <= 1'b0;
            r_retired_count <= 32'd0;
        end else begin
            if (w_resp_take) begin
                r_instr       <= imem_resp_data;
                r_instr_valid <= 1'b1;
            end
            if (w_retire_take) begin
                r_retired_count <= r_retired_count + 32'd1;
                r_instr_valid   <= 1'b0;
                if (w_new_pc_ok) begin
                    r_pc <= new_pc;
                end else begin
                    // PC keeps the address of the retiring instruction for debug
                    r_fetch_fault <= 1'b1;
                end
            end
        end
    end

    assign imem_req_valid = (r_state == ST_REQUEST);
    assign imem_addr      = r_pc;
    assign instr_valid    = r_instr_valid;
    assign instr          = r_instr;
    assign pc             = r_pc;
    assign pc_plus4       = r_pc + 32'd4;
    assign fetch_fault    = r_fetch_fault;
    assign retired_count  = r_retired_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a hand-driven instruction memory.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// Acceptances are counted independently of the DUT state.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        retire;
    logic [31:0] new_pc;
    logic        fetch_fault;
    logic [31:0] retired_count;

    int n_checks = 0;
    int n_errors = 0;
    int acc_cnt  = 0;
    int acc0     = 0;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_VECTOR(32'h0000_0100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .retire         (retire),
        .new_pc         (new_pc),
        .fetch_fault    (fetch_fault),
        .retired_count  (retired_count)
    );

    // Count request handshakes as the memory sees them
    always @(posedge clk) begin
        if (rst_n && imem_req_valid && imem_req_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                            input int req_delay, input int resp_delay, input bit hold_ready);
        int a0;
        a0 = acc_cnt;
        chk("req_vld", 32'(imem_req_valid), 32'd1);
        chk("req_addr", imem_addr, addr);
        for (int i = 0; i < req_delay; i++) begin
            tick();
            chk("req_vld_stall", 32'(imem_req_valid), 32'd1);
            chk("req_addr_stall", imem_addr, addr);
        end
        imem_req_ready = 1'b1;
        tick();
        if (!hold_ready) imem_req_ready = 1'b0;
        chk("acc_once", 32'(acc_cnt - a0), 32'd1);
        chk("wait_req_vld", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < resp_delay; i++) begin
            tick();
            chk("wait_instr_vld", 32'(instr_valid), 32'd0);
            chk("wait_req_vld", 32'(imem_req_valid), 32'd0);
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        tick();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        imem_req_ready  = 1'b0;
        chk("instr_vld", 32'(instr_valid), 32'd1);
        chk("instr", instr, data);
        chk("pc", pc, addr);
        chk("pc_plus4", pc_plus4, addr + 32'd4);
        chk("acc_total", 32'(acc_cnt - a0), 32'd1);
    endtask

    task automatic do_retire(input logic [31:0] npc);
        retire = 1'b1;
        new_pc = npc;
        tick();
        retire = 1'b0;
        new_pc = 32'd0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pc"}, pc, 32'h0000_0100);
        chk({tag, "_pc4"}, pc_plus4, 32'h0000_0104);
        chk({tag, "_instr"}, instr, 32'h0000_0013);
        chk({tag, "_ivld"}, 32'(instr_valid), 32'd0);
        chk({tag, "_fault"}, 32'(fetch_fault), 32'd0);
        chk({tag, "_cnt"}, retired_count, 32'd0);
        chk({tag, "_req"}, 32'(imem_req_valid), 32'd1);
        chk({tag, "_addr"}, imem_addr, 32'h0000_0100);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        retire          = 1'b0;
        new_pc          = 32'd0;
        tick();
        tick();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();
        chk("post_rst_req", 32'(imem_req_valid), 32'd1);

        // Zero-wait memory at the reset vector
        do_fetch(32'h0000_0100, 32'h0010_0093, 0, 0, 1'b0);
        do_retire(32'h0000_0104);
        chk("ret1_cnt", retired_count, 32'd1);
        chk("ret1_pc", pc, 32'h0000_0104);
        chk("ret1_ivld", 32'(instr_valid), 32'd0);
        chk("ret1_req", 32'(imem_req_valid), 32'd1);

        // Request stalled 5 cycles, ready left high, response 4 cycles late
        do_fetch(32'h0000_0104, 32'h0050_0093, 5, 4, 1'b1);

        // Two retires to the same target
        do_retire(32'h0000_0200);
        chk("ret2_cnt", retired_count, 32'd2);
        do_fetch(32'h0000_0200, 32'h00a0_0113, 0, 1, 1'b0);
        do_retire(32'h0000_0200);
        chk("ret3_cnt", retired_count, 32'd3);
        chk("ret3_req", 32'(imem_req_valid), 32'd1);
        do_fetch(32'h0000_0200, 32'h0000_006f, 0, 0, 1'b0);

        // pc_plus4 wrap at the top of the address space
        do_retire(32'hFFFF_FFFC);
        chk("wrap_cnt", retired_count, 32'd4);
        chk("wrap_pc4", pc_plus4, 32'd0);
        do_fetch(32'hFFFF_FFFC, 32'h1234_5678, 1, 0, 1'b0);

        // Misaligned target -> sticky fault
        do_retire(32'h0000_0202);
        chk("flt", 32'(fetch_fault), 32'd1);
        chk("flt_cnt", retired_count, 32'd5);
        chk("flt_pc", pc, 32'hFFFF_FFFC);
        chk("flt_ivld", 32'(instr_valid), 32'd0);
        chk("flt_req", 32'(imem_req_valid), 32'd0);
        acc0           = acc_cnt;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            retire = 1'b1;
            new_pc = 32'h0000_0300;
            tick();
            chk("flt_hold_cnt", retired_count, 32'd5);
            chk("flt_hold", 32'(fetch_fault), 32'd1);
            chk("flt_hold_req", 32'(imem_req_valid), 32'd0);
        end
        retire         = 1'b0;
        new_pc         = 32'd0;
        imem_req_ready = 1'b0;
        chk("flt_no_acc", 32'(acc_cnt - acc0), 32'd0);

        // Asynchronous reset out of FAULT
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst_flt");
        tick();
        rst_n = 1'b1;
        do_fetch(32'h0000_0100, 32'h0020_0093, 0, 0, 1'b0);
        do_retire(32'h0000_0300);
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("pre_arst_wait_req", 32'(imem_req_valid), 32'd0);
        chk("pre_arst_pc", pc, 32'h0000_0300);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst_wait");
        tick();
        rst_n = 1'b1;

        // Stray retire and response while in REQUEST are ignored
        retire          = 1'b1;
        new_pc          = 32'h0000_0400;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        retire          = 1'b0;
        new_pc          = 32'd0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'd0;
        chk("stray_cnt", retired_count, 32'd0);
        chk("stray_pc", pc, 32'h0000_0100);
        chk("stray_ivld", 32'(instr_valid), 32'd0);
        chk("stray_instr", instr, 32'h0000_0013);
        do_fetch(32'h0000_0100, 32'h0030_0093, 0, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
